// File: rtl/d7seg_scan_ctrl.sv
// Multiplexed 7-segment display scan controller.
// Loads segment patterns into a shadow register, either frame-synchronously
// (scan modes) or on the cycle after capture (off/static). It scans one digit per
// 2^SCAN_BITS-clock slot and applies 16-level PWM brightness and optional frame blinking.
// All pin outputs come from registers; polarity inversion sits after those registers.
module d7seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_BITS    = 10,
  parameter int BLINK_FRAMES = 64,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [NUM_DIGITS*8-1:0] digits_i,
  input  logic                    update_i,
  input  logic [1:0]              mode_i,
  input  logic [3:0]              brightness_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   dig_en_o,
  output logic                    frame_o,
  output logic                    busy_o
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PWM_LSB = SCAN_BITS - 4;

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]      BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [SCAN_BITS-1:0]  PRE_MAX  = {SCAN_BITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_STATIC = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

  logic [NUM_DIGITS*8-1:0] shadow;
  logic [NUM_DIGITS*8-1:0] staging;
  logic                    pending;
  logic [SCAN_BITS-1:0]    prescaler;
  logic [IDX_W-1:0]        idx;
  logic [BLK_W-1:0]        blink_cnt;
  logic                    blink_phase;
  mode_t                   mode_prev;
  logic [7:0]              seg_q;
  logic [NUM_DIGITS-1:0]   dig_q;
  logic                    frame_q;

  mode_t                   mode_s;
  logic                    scan_mode;
  logic                    mode_chg;
  logic                    pre_wrap;
  logic                    frame_evt;
  logic                    copy_slot;
  logic                    lit;
  logic [3:0]              pwm_phase;
  logic [7:0]              cur_digit;
  logic [7:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_n;

  assign mode_s    = mode_t'(mode_i);
  assign scan_mode = mode_i[1];
  assign mode_chg  = (mode_s != mode_prev);
  assign pre_wrap  = (prescaler == PRE_MAX);
  assign frame_evt = pre_wrap && (idx == IDX_LAST);
  assign pwm_phase = prescaler[SCAN_BITS-1:PWM_LSB];
  assign lit       = (pwm_phase <= brightness_i);
  // Scan modes swap data only at a frame boundary; off/static swap as soon as pending.
  assign copy_slot = scan_mode ? frame_q : pending;

  // Select the shadow byte of the digit currently being scanned.
  always_comb begin
    cur_digit = 8'h00;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cur_digit = (idx == IDX_W'(k)) ? shadow[8*k +: 8] : cur_digit;
    end
  end

  // Next segment/digit drive from mode, PWM phase, blink phase and shadow data.
  always_comb begin
    seg_n = 8'h00;
    dig_n = {NUM_DIGITS{1'b0}};
    case (mode_s)
      MODE_OFF: begin
        seg_n = 8'h00;
        dig_n = {NUM_DIGITS{1'b0}};
      end
      MODE_STATIC: begin
        seg_n = shadow[7:0];
        dig_n = DIG_ONE;
      end
      MODE_SCAN, MODE_BLINK: begin
        if (lit && !((mode_s == MODE_BLINK) && blink_phase)) begin
          seg_n = cur_digit;
          dig_n = DIG_ONE << idx;
        end else begin
          seg_n = 8'h00;
          dig_n = {NUM_DIGITS{1'b0}};
        end
      end
      default: begin
        seg_n = 8'h00;
        dig_n = {NUM_DIGITS{1'b0}};
      end
    endcase
  end

  // Staging/shadow data path; a request landing on the swap cycle goes straight to shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= {(NUM_DIGITS*8){1'b0}};
      staging <= {(NUM_DIGITS*8){1'b0}};
      pending <= 1'b0;
    end else if (ena) begin
      if (update_i && copy_slot) begin
        shadow  <= digits_i;
        staging <= digits_i;
        pending <= 1'b0;
      end else if (update_i) begin
        staging <= digits_i;
        pending <= 1'b1;
      end else if (copy_slot && pending) begin
        shadow  <= staging;
        pending <= 1'b0;
      end
    end
  end

  // Prescaler, digit index, frame pulse and blink counters; cleared on mode change or outside scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_prev   <= MODE_OFF;
      prescaler   <= {SCAN_BITS{1'b0}};
      idx         <= {IDX_W{1'b0}};
      blink_cnt   <= {BLK_W{1'b0}};
      blink_phase <= 1'b0;
      frame_q     <= 1'b0;
    end else if (ena) begin
      mode_prev <= mode_s;
      if (mode_chg || !scan_mode) begin
        prescaler   <= {SCAN_BITS{1'b0}};
        idx         <= {IDX_W{1'b0}};
        blink_cnt   <= {BLK_W{1'b0}};
        blink_phase <= 1'b0;
        frame_q     <= 1'b0;
      end else begin
        prescaler <= prescaler + SCAN_BITS'(1);
        frame_q   <= frame_evt;
        if (pre_wrap) begin
          idx <= (idx == IDX_LAST) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
        end
        if (frame_evt && (mode_s == MODE_BLINK)) begin
          if (blink_cnt == BLK_LAST) begin
            blink_cnt   <= {BLK_W{1'b0}};
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
          end
        end
      end
    end
  end

  // Output registers: one cycle behind the internal scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 8'h00;
      dig_q <= {NUM_DIGITS{1'b0}};
    end else if (ena) begin
      seg_q <= seg_n;
      dig_q <= dig_n;
    end
  end

  assign seg_o    = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dig_en_o = ACTIVE_LOW ? ~dig_q : dig_q;
  // A held frame pulse stays invisible while frozen and reappears when counting resumes.
  assign frame_o  = frame_q & ena;
  assign busy_o   = pending;

endmodule

// File: doc/d7seg_scan_ctrl.md
D7SEG_SCAN_CTRL -- requirements
Module: d7seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter SCAN_BITS, default 10, giving 2^SCAN_BITS clocks per digit slot (minimum 4).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, number of frames per blink half-period (minimum 1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 0; 1 inverts seg_o and dig_en_o at the pins.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ena  input  1  count enable; 0 freezes all state.
REQ-008 SHALL have port digits_i  input  NUM_DIGITS*8  segment patterns, digit k at [8k+7:8k], bit 7 = decimal point.
REQ-009 SHALL have port update_i  input  1  request to load digits_i into the shadow register.
REQ-010 SHALL have port mode_i  input  2  00 off, 01 static, 10 scan, 11 scan+blink.
REQ-011 SHALL have port brightness_i  input  4  PWM duty code.
REQ-012 SHALL have port seg_o  output  8  segment drive, registered.
REQ-013 SHALL have port dig_en_o  output  NUM_DIGITS  digit enable, one-hot or zero, registered.
REQ-014 SHALL have port frame_o  output  1  one-cycle pulse at end of each scan frame.
REQ-015 SHALL have port busy_o  output  1  high while an update request is pending.

Function
REQ-016 SHALL hold a NUM_DIGITS*8 shadow register; seg_o is always sourced from the shadow, never directly from digits_i.
REQ-017 SHALL, on update_i=1 with ena=1, capture digits_i into a staging register and set pending; a later update_i while pending overwrites staging.
REQ-018 SHALL copy staging to shadow and clear pending in the cycle frame_o is asserted; in off or static mode the copy occurs on the cycle after capture.
REQ-019 SHALL, when update_i and the shadow-copy event coincide, copy the same-cycle digits_i to shadow and leave pending clear.
REQ-020 SHALL drive busy_o = pending.
REQ-021 SHALL run a SCAN_BITS-wide prescaler in scan modes, incrementing when ena=1, wrapping 2^SCAN_BITS-1 -> 0.
REQ-022 SHALL advance digit index on prescaler wrap, index NUM_DIGITS-1 -> 0; frame_o pulses on the cycle index wraps to 0.
REQ-023 SHALL define pwm_phase = prescaler[SCAN_BITS-1:SCAN_BITS-4]; segments lit only while pwm_phase <= brightness_i (code 0 = 1/16 duty, 15 = 100%).
REQ-024 SHALL, in scan modes, drive dig_en_o one-hot at the current index and seg_o = shadow digit at index when lit, else seg_o = 0 and dig_en_o = 0.
REQ-025 SHALL, in mode 11, count frames and toggle blink_phase every BLINK_FRAMES frames; blink_phase=1 forces seg_o=0, dig_en_o=0.
REQ-026 SHALL, in mode 01, drive seg_o = shadow digit 0, dig_en_o = bit 0 only, no PWM or blink, prescaler, index and blink counter held at 0.
REQ-027 SHALL, in mode 00, drive seg_o = 0, dig_en_o = 0, frame_o = 0, counters held at 0.
REQ-028 SHALL, on any change of mode_i, clear prescaler, index, blink counter and blink_phase on the following edge.
REQ-029 SHALL, with ena=0, hold all registers including outputs; update_i ignored; frame_o = 0.
REQ-030 SHALL present outputs with one cycle latency from internal state (registered outputs); ACTIVE_LOW inversion applied after the register.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously clear shadow, staging, pending, prescaler, index, blink counter, blink_phase.
REQ-032 SHALL, during and after reset, drive seg_o and dig_en_o inactive (all 0, or all 1 if ACTIVE_LOW=1), frame_o = 0, busy_o = 0.
REQ-033 SHALL abandon any pending update on reset mid-frame; first frame after release starts at index 0, prescaler 0.

Verification
REQ-034 SHALL verify: NUM_DIGITS=4, SCAN_BITS=4, mode 10, brightness 15, shadow 0x11_22_33_44 -> dig_en_o 0001/0010/0100/1000 each 16 clocks with seg_o 0x44/0x33/0x22/0x11, frame_o every 64 clocks.
REQ-035 SHALL verify: brightness 3, SCAN_BITS=4 -> seg_o lit 4 of 16 clocks per slot (pwm_phase 0..3), dark 12.
REQ-036 SHALL verify: update_i mid-frame with 0xAA.. -> busy_o=1, displayed data unchanged until frame_o, shadow updated at frame_o, busy_o=0 next cycle; update_i coincident with frame_o loads same-cycle data.
REQ-037 SHALL verify: mode 11, BLINK_FRAMES=2 -> outputs active 2 frames, blank 2 frames, repeating; switch to mode 01 -> seg_o = digit 0 constant, dig_en_o=0001.
REQ-038 SHALL verify: ena=0 for 10 clocks mid-slot -> all outputs and counters frozen, scan resumes from same prescaler value.
REQ-039 SHALL verify: rst_n asserted mid-frame with ACTIVE_LOW=1 -> seg_o=0xFF, dig_en_o all 1 immediately (asynchronous), busy_o=0, restart at index 0.
